// File: rtl/down_counter_pkg.sv
// Shared types and reset constants for the loadable down-counter/timer.
package down_counter_pkg;

    // Controller states: IDLE (parked), RUN (counting), DONE (expired, no reload).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Values forced by the synchronous active-low reset.
    localparam state_t STATE_RST = IDLE;
    localparam logic   TC_RST    = 1'b0;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// Loadable N-bit down-counter/timer with terminal-count pulse and optional
// auto-reload. A load always wins over counting, and a load of zero parks the
// block in IDLE. In RUN with en=1 the count steps down. When the count goes
// from 1 to the next value the block has expired: tc pulses for one cycle, and
// the count either restarts from the captured reload value or stops in DONE.
//
// There is no valid/ready handshake. load and en are sampled on every rising
// clock edge. State is reported through dbg_state so checkers can bind to it.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         auto_reload,
    output logic [N-1:0] cnt,
    output logic         tc,
    output logic         busy,
    output logic         done,
    output state_t       dbg_state
);

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] reload_q, reload_d;
    logic         tc_q, tc_d;

    // Next-state logic: load > expiry/decrement > hold; tc defaults low so it is one cycle wide.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            reload_d = load_val;
            cnt_d    = load_val;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Parked: count held, en has no effect.
                end
                RUN: begin
                    if (en) begin
                        if (cnt_q == CNT_ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                // Period is reload_q enabled cycles; 0 is never shown.
                                cnt_d = reload_q;
                            end else begin
                                cnt_d   = '0;
                                state_d = DONE;
                            end
                        end else if (cnt_q == '0) begin
                            // A load of zero never enters RUN, so this is unreachable.
                            // Park in IDLE anyway so the count cannot wrap.
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                DONE: begin
                    // Expired: hold zero until the next load or reset.
                    cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, count, reload value and tc registers; synchronous active-low reset wins over everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= STATE_RST;
            cnt_q    <= '0;
            reload_q <= '0;
            tc_q     <= TC_RST;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign cnt       = cnt_q;
    assign tc        = tc_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule : down_counter
